// File: rtl/truth_table_sweeper_pkg.sv
// truth_table_sweeper_pkg: shared state encoding, compare modes and table sizing
package truth_table_sweeper_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic CMP_PAIR = 1'b0;
  localparam logic CMP_GOLDEN = 1'b1;
  function automatic int truth_width(input int n_in, input int n_out);
    return (1 << n_in) * n_out;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// sweep_counter: steps vec through every combination, holding each for HOLD_CYCLES cycles
module sweep_counter #(
  parameter int N_IN = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            run,
  output logic [N_IN-1:0] vec,
  output logic            sample,
  output logic            last
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  logic [HW-1:0] hold_cnt;
  assign sample = hold_cnt == HW'(HOLD_CYCLES - 1);
  assign last = &vec;
  // hold each vector, then advance; the all-ones vector is held as the final value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      hold_cnt <= '0;
    end else if (clear) begin
      vec <= '0;
      hold_cnt <= '0;
    end else if (run) begin
      if (!sample) hold_cnt <= hold_cnt + 1'b1;
      else if (!last) begin
        vec <= vec + 1'b1;
        hold_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive sweep comparing y_a against y_b or a golden truth table
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_OUT = 1,
  parameter int HOLD_CYCLES = 1,
  parameter logic [truth_width(N_IN, N_OUT)-1:0] TRUTH = 8'b1110_1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_mode,
  input  logic [N_OUT-1:0] y_a,
  input  logic [N_OUT-1:0] y_b,
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    mismatch_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);
  state_t state, next_state;
  logic mode, sample, last, clear, step, mis;
  logic [N_OUT-1:0] ref_y;
  assign busy = state == SWEEP;
  assign done = state == DONE;
  assign clear = start && state != SWEEP;
  assign step = busy && sample;
  assign ref_y = mode == CMP_GOLDEN ? TRUTH[int'(vec)*N_OUT +: N_OUT] : y_b;
  assign mis = step && (y_a != ref_y);
  sweep_counter #(.N_IN(N_IN), .HOLD_CYCLES(HOLD_CYCLES)) u_cnt (
    .clk(clk), .rst(rst), .clear(clear), .run(busy),
    .vec(vec), .sample(sample), .last(last)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  // accept start outside a sweep; finish after sampling the all-ones vector
  always_comb begin
    next_state = state;
    next_state = clear ? SWEEP : (step && last) ? DONE : state;
  end
  // result registers: cleared on accepted start, updated on each sample cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode <= CMP_PAIR;
      pass <= 1'b0;
      mismatch_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec <= '0;
    end else if (clear) begin
      mode <= cmp_mode;
      pass <= 1'b0;
      mismatch_count <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec <= '0;
    end else if (step) begin
      if (mis) mismatch_count <= mismatch_count + 1'b1;
      if (mis && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec <= vec;
      end
      if (last) pass <= mismatch_count == '0 && !mis;
    end
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Exhaustive truth-table sweeper and equivalence checker for gate-level minimisation exercises. It drives every N_IN-bit input combination in ascending order into two candidate implementations, such as NAND-only and NOR-only realisations. It compares their outputs, or one output against a golden truth table, and reports the mismatch count, the first failing vector and a pass/fail flag. It sits in lab benches and on-board self-test wrappers in place of hand-written stimulus sequences.

Parameters:
N_IN, 3, number of function inputs (1..16)
N_OUT, 1, output width of each implementation under check
HOLD_CYCLES, 1, clock cycles each vector is held before sampling (>=1; covers combinational settle)
TRUTH, 8'b1110_1000, golden table; width (2**N_IN)*N_OUT; vector v occupies bits [v*N_OUT +: N_OUT]

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sweep
cmp_mode  in  1  0 = compare y_a against y_b; 1 = compare y_a against TRUTH; sampled with start
y_a  in  N_OUT  output of implementation A
y_b  in  N_OUT  output of implementation B; ignored when cmp_mode=1
vec  out  N_IN  current input combination driven to both implementations
busy  out  1  sweep in progress
done  out  1  sweep complete; level, held until next accepted start
pass  out  1  done and mismatch_count==0
mismatch_count  out  N_IN+1  number of failing vectors (max 2**N_IN, no saturation needed)
first_fail_valid  out  1  at least one mismatch recorded
first_fail_vec  out  N_IN  lowest failing vector; valid only with first_fail_valid

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- While rst is high, every output is 0 and the state is IDLE. Reset takes effect immediately, including mid-sweep. The partial result is discarded.
- States: IDLE, SWEEP, DONE. Output mapping: busy=1 only in SWEEP; done=1 only in DONE.
- IDLE or DONE, start=1 at edge E:
  - Enter SWEEP. Clear mismatch_count, first_fail_valid, first_fail_vec and done.
  - Set vec=0 and hold_cnt=0. Latch cmp_mode.
- start while in SWEEP is ignored.
- SWEEP, each cycle:
  - If hold_cnt < HOLD_CYCLES-1, increment hold_cnt.
  - Otherwise this is the sample cycle. Combinationally compare y_a with the reference (y_b, or the TRUTH slice for vec). At the edge:
    - On mismatch, increment mismatch_count.
    - If first_fail_valid=0 on that mismatch, load first_fail_vec=vec and set first_fail_valid.
  - Then, at the same edge:
    - If vec == 2**N_IN-1, go to DONE. vec holds its final value.
    - Otherwise vec+1 and hold_cnt=0.
- Latency: done rises at edge E + (2**N_IN)*HOLD_CYCLES. Each vector is driven for exactly HOLD_CYCLES cycles.
- vec wrap: vec never wraps. Termination is on the all-ones vector.
- mismatch_count is wide enough for all-fail: 2**N_IN fits in N_IN+1 bits.
- pass is registered and equals done && (mismatch_count==0). It is cleared by start.
- The comparison is full-width equality across all N_OUT bits. Any differing bit counts as one mismatch for that vector.
- Inputs y_a and y_b are purely combinational functions of vec. No input synchronisation is provided.

Decomposition:
- Package truth_table_sweeper_pkg:
  - state enum {IDLE, SWEEP, DONE}
  - localparams CMP_PAIR=1'b0 and CMP_GOLDEN=1'b1
  - function for the TRUTH slice width
- One sub-module, sweep_counter: the vec register, the hold_cnt timer and the last-sample/terminal flags. The parent keeps the FSM, comparison and result registers.

Test Plan:
1. N_IN=3, HOLD=1, cmp_mode=0, y_a=y_b=majority(vec); pulse start -> vec steps 0..7, one per cycle; done and pass high 8 cycles after start; mismatch_count=0; first_fail_valid=0.
2. As scenario 1, but y_b inverted only when vec==5 -> mismatch_count=1, first_fail_vec=5, first_fail_valid=1, pass=0.
3. HOLD_CYCLES=3, identical functions -> each vec held 3 cycles; done at cycle 24; pass=1.
4. cmp_mode=1, TRUTH=8'b1110_1000. Run y_a=majority, then y_a=0 -> first run pass=1. Second run mismatch_count=4, first_fail_vec=3.
5. Assert rst while vec==4 mid-sweep -> all outputs 0 immediately. A start pulsed during SWEEP in another run is ignored; vec sequence is unaffected.
6. From DONE with failures recorded, pulse start with matching functions -> done drops next cycle; results cleared; the new sweep ends with pass=1.
